// File: rtl/ysyx_23060201_mem_arb.sv
// rtl/ysyx_23060201_mem_arb.sv - round-robin IFU/LSU arbiter onto a single-port registered memory
module ysyx_23060201_mem_arb #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ifu_req_valid,
    output logic                      ifu_req_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] ifu_addr,
    output logic                      ifu_rsp_valid,
    input  logic                      ifu_rsp_ready,
    output logic [DATA_WIDTH-1:0]     ifu_rdata,
    input  logic                      lsu_req_valid,
    output logic                      lsu_req_ready,
    input  logic                      lsu_req_wen,
    input  logic [MEM_ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0]     lsu_wdata,
    input  logic [7:0]                lsu_wmask,
    input  logic [7:0]                lsu_rmask,
    output logic                      lsu_rsp_valid,
    input  logic                      lsu_rsp_ready,
    output logic [DATA_WIDTH-1:0]     lsu_rdata,
    output logic                      mem_wen,
    output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]                mem_wmask,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic                      mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
    output logic [7:0]                mem_rmask,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                    state, state_nxt;
    logic                      owner_lsu;
    logic                      last_lsu;
    logic [MEM_ADDR_WIDTH-1:0] lat_addr;
    logic                      lat_wen;
    logic [DATA_WIDTH-1:0]     lat_wdata;
    logic [7:0]                lat_wmask;
    logic [7:0]                lat_rmask;
    logic [DATA_WIDTH-1:0]     ifu_rdata_q;
    logic [DATA_WIDTH-1:0]     lsu_rdata_q;
    logic                      grant_ifu, grant_lsu;
    logic                      rsp_fire;
    logic                      rd_issue, wr_issue;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (!rst && state == IDLE) begin
            if (ifu_req_valid && lsu_req_valid) begin
                grant_lsu = !last_lsu;
                grant_ifu = last_lsu;
            end else begin
                grant_ifu = ifu_req_valid;
                grant_lsu = lsu_req_valid;
            end
        end
    end

    assign rsp_fire = (state == RESP) && (owner_lsu ? lsu_rsp_ready : ifu_rsp_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_ifu || grant_lsu) state_nxt = ISSUE;
            ISSUE:   state_nxt = lat_wen ? RESP : WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner_lsu   <= 1'b0;
            last_lsu    <= 1'b0;
            lat_addr    <= '0;
            lat_wen     <= 1'b0;
            lat_wdata   <= '0;
            lat_wmask   <= 8'h00;
            lat_rmask   <= 8'h00;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (grant_lsu) begin
                owner_lsu <= 1'b1;
                last_lsu  <= 1'b1;
                lat_addr  <= lsu_addr;
                lat_wen   <= lsu_req_wen;
                lat_wdata <= lsu_wdata;
                lat_wmask <= lsu_wmask;
                lat_rmask <= lsu_rmask;
            end else if (grant_ifu) begin
                owner_lsu <= 1'b0;
                last_lsu  <= 1'b0;
                lat_addr  <= ifu_addr;
                lat_wen   <= 1'b0;
                lat_wdata <= '0;
                lat_wmask <= 8'h00;
                lat_rmask <= 8'h0F;
            end
            // Writes answer with zero data; reads capture the memory word one cycle after the strobe.
            if (state == ISSUE && lat_wen && owner_lsu) lsu_rdata_q <= '0;
            if (state == WAIT) begin
                if (owner_lsu) lsu_rdata_q <= mem_rdata;
                else           ifu_rdata_q <= mem_rdata;
            end
        end
    end

    assign rd_issue = !rst && (state == ISSUE) && !lat_wen;
    assign wr_issue = !rst && (state == ISSUE) && lat_wen;

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;
    assign ifu_rsp_valid = !rst && (state == RESP) && !owner_lsu;
    assign lsu_rsp_valid = !rst && (state == RESP) && owner_lsu;
    assign ifu_rdata     = rst ? '0 : ifu_rdata_q;
    assign lsu_rdata     = rst ? '0 : lsu_rdata_q;

    assign mem_ren   = rd_issue;
    assign mem_raddr = rd_issue ? lat_addr : '0;
    assign mem_rmask = rd_issue ? lat_rmask : 8'h00;
    assign mem_wen   = wr_issue;
    assign mem_waddr = wr_issue ? lat_addr : '0;
    assign mem_wdata = wr_issue ? lat_wdata : '0;
    assign mem_wmask = wr_issue ? lat_wmask : 8'h00;

endmodule
